cenn_pixel_streamer: RTL and testbench
======================================

# cenn_pixel_streamer

Frame reader that walks a synchronous single-port image RAM in raster order and emits the pixel stream (`out`, `read_ready`) consumed by the CeNN state/delay registers and mask pipeline. It is the producer end of the `read_ready`/`out` interface. It issues addresses, absorbs the RAM's 1-cycle read latency, supports stalls and start/busy/done control, and optionally injects a fixed boundary ring around the frame.

## Interface
- `width`, 8, pixel/state word width
- `ROWS`, 16, frame rows (≥2)
- `COLS`, 16, frame columns (≥2)
- `ADDR_W`, `$clog2(ROWS*COLS)`, RAM address width
- `BOUNDARY`, 0, boundary pixel value (used only with padding)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, synchronous, active-high
- `start` in 1: begin a frame; sampled only in IDLE
- `stall` in 1: suppresses new RAM issues while high
- `mem_en` out 1: RAM read enable (combinational from state)
- `mem_addr` out ADDR_W: RAM read address (registered counter)
- `mem_data` in width: RAM read data, valid 1 cycle after `mem_en`
- `out` out width: streamed pixel
- `read_ready` out 1: `out` valid this cycle
- `busy` out 1: frame in progress
- `done` out 1: one-cycle pulse with the last pixel

## Operation
- FSM states and transitions:
  - IDLE: `start` → FETCH; clear counters.
  - FETCH: advance one position per cycle when `!stall`. After the last position is issued → DRAIN.
  - DRAIN: wait for in-flight pixels → DONE.
  - DONE: single cycle → IDLE.
- `mem_en` = FETCH && `!stall` && current position is an image pixel.
- `mem_addr` is a linear counter. It increments only on an issued read and is never computed as row*COLS.
- Row/column counters track raster position.
- Column wrap: at column = last, column returns to 0 and row increments.
- After the last column of the last row: no further issue; state moves to DRAIN.
- Two-stage valid pipeline:
  - Stage 1: issue flag plus pad flag.
  - Stage 2: `read_ready` and `out`.
  - `out` takes `mem_data` for image positions and `BOUNDARY` for pad positions.
- Stall behaviour:
  - Stall never drops in-flight data; pixels issued before `stall` rose are still delivered.
  - `read_ready` gaps match stall cycles.
- `busy` is high from the cycle after `start` is accepted through the `done` cycle inclusive.
- `start` while busy is ignored.
- `done` is coincident with the final `read_ready`.
- `rst` at any time, including mid-frame:
  - state → IDLE and pipelines cleared.
  - In-flight data is discarded; no `done` is generated for the aborted frame.
- Reset values: `mem_en`=0, `mem_addr`=0, `out`=0, `read_ready`=0, `busy`=0, `done`=0.

## Timing
- Address issued at cycle t → `out`/`read_ready` at t+2.
- Unstalled frame of N positions: `start` at cycle 0 → first `read_ready` at cycle 3 → last pixel plus `done` at cycle N+2.
- `read_ready` is continuous (no bubbles) when `stall` is low.
- Back-to-back frames: the next `start` is accepted in the first IDLE cycle after DONE.

## Configuration
- `CENN_STREAMER_PAD_EN` defined:
  - The traversal covers (ROWS+2)×(COLS+2) positions.
  - Row 0, row ROWS+1, column 0 and column COLS+1 are pad positions: no RAM read, value `BOUNDARY`, same 2-cycle latency, same stall behaviour.
  - `mem_addr` still increments only on image pixels.
- Not defined:
  - Exactly ROWS×COLS image positions.
  - The pad logic is absent.
  - `BOUNDARY` is unused.

## Structure
- Shared package `cenn_pkg`:
  - FSM state enum (IDLE, FETCH, DRAIN, DONE).
  - Default `width`, `ROWS`, `COLS` constants, and the padded-dimension helper constants.
- One sub-module, `cenn_raster_counter`:
  - Row/column counter with enable, wrap, and last-position flag.
  - Parameterised on dimensions, so the padded and unpadded traversals share it.

## Test plan
- ROWS=COLS=4, RAM holds addr value; pulse `start`, no stall → `read_ready` high 16 consecutive cycles from cycle 3; `out`=0..15; `done` at cycle 18; `busy` cycles 1–18.
- Same frame, `stall` high cycles 5–7 → exactly 3-cycle `read_ready` gap, 16 pixels in order, no duplicates, `done` delayed by 3.
- `start` pulsed again at cycle 8 mid-frame → ignored; single `done`; next `start` after IDLE runs a fresh frame from address 0.
- `rst` at cycle 10 mid-frame → next cycle all outputs 0, no `done`; a subsequent `start` streams 0..15 correctly.
- `CENN_STREAMER_PAD_EN`, 4×4, `BOUNDARY`=8'hFF:
  - 36 `read_ready` pulses.
  - First 7 and last 7 are FF; interior 4×4 is 0..15.
  - `mem_en` asserted exactly 16 times.
- Stall held through the last FETCH cycle → the final pixel is delivered only after stall release, and `done` stays aligned with it.

Source files
------------

// File: rtl/cenn_pixel_streamer_pkg.sv
//------------------------------------------------------------------------------
// Package     : cenn_pkg
// Description : Shared types and constants for the CeNN pixel streamer:
//               FSM state encoding, default frame geometry and the helper
//               that derives padded traversal dimensions.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cenn_pkg;

   // Streamer control states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Default frame geometry
   localparam int CENN_WIDTH    = 8;
   localparam int CENN_ROWS     = 16;
   localparam int CENN_COLS     = 16;

   // Width of the boundary ring added on each side of a padded frame
   localparam int CENN_PAD_RING = 1;

   // Traversal extent of one dimension once the boundary ring is added
   function automatic int padded_dim(input int dim);
      return dim + 2 * CENN_PAD_RING;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cenn_pixel_streamer_if.sv
//------------------------------------------------------------------------------
// Interface   : cenn_pixel_streamer_if
// Description : Control, RAM-read and pixel-stream signals of the CeNN pixel
//               streamer. The master modport is the streamer itself; the
//               slave modport is the surrounding RAM/consumer/controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cenn_pixel_streamer_if
   import cenn_pkg::*;
#(
   parameter int width  = CENN_WIDTH,
   parameter int ADDR_W = $clog2(CENN_ROWS * CENN_COLS)
);

   logic              start;
   logic              stall;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [width-1:0]  mem_data;
   logic [width-1:0]  out;
   logic              read_ready;
   logic              busy;
   logic              done;

   modport master (
      input  start, stall, mem_data,
      output mem_en, mem_addr, out, read_ready, busy, done
   );

   modport slave (
      output start, stall, mem_data,
      input  mem_en, mem_addr, out, read_ready, busy, done
   );

endinterface

`default_nettype wire

// File: rtl/cenn_pixel_streamer_raster_counter.sv
//------------------------------------------------------------------------------
// Module      : cenn_raster_counter
// Description : Raster-order row/column position counter with enable,
//               synchronous clear, column/row wrap and a last-position flag.
//               Dimensions are parameters so padded and unpadded traversals
//               share the same counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cenn_raster_counter #(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int RW   = $clog2(ROWS),
   parameter int CW   = $clog2(COLS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic [RW-1:0] row,
   output logic [CW-1:0] col,
   output logic          last
);

   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          col_last;
   logic          row_last;

   assign col_last = (col_q == CW'(COLS - 1));
   assign row_last = (row_q == RW'(ROWS - 1));

   // Next position: clear wins, otherwise step one column and wrap into the next row
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clr) begin
         row_d = '0;
         col_d = '0;
      end else if (en) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // Position registers
   always_ff @(posedge clk) begin
      if (rst) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign row  = row_q;
   assign col  = col_q;
   assign last = row_last && col_last;

endmodule

`default_nettype wire

// File: rtl/cenn_pixel_streamer.sv
//------------------------------------------------------------------------------
// Module      : cenn_pixel_streamer
// Description : Walks a synchronous single-port image RAM in raster order and
//               streams the pixels (out/read_ready) with start/busy/done
//               control, stall support and a 2-cycle issue-to-output latency.
//               Define CENN_STREAMER_PAD_EN to wrap the frame in a one-pixel
//               BOUNDARY ring that is produced without RAM reads.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cenn_pixel_streamer
   import cenn_pkg::*;
#(
   parameter int               width    = CENN_WIDTH,
   parameter int               ROWS     = CENN_ROWS,
   parameter int               COLS     = CENN_COLS,
   parameter int               ADDR_W   = $clog2(ROWS * COLS),
   parameter logic [width-1:0] BOUNDARY = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   cenn_pixel_streamer_if.master  bus
);

`ifdef CENN_STREAMER_PAD_EN
   localparam int T_ROWS = padded_dim(ROWS);
   localparam int T_COLS = padded_dim(COLS);
`else
   localparam int T_ROWS = ROWS;
   localparam int T_COLS = COLS;
`endif
   localparam int RW = $clog2(T_ROWS);
   localparam int CW = $clog2(T_COLS);

   state_e            state_q;
   logic              busy_q;
   logic              done_q;

   logic [RW-1:0]     pos_row;
   logic [CW-1:0]     pos_col;
   logic              pos_last;
   logic              pos_pad;
   logic              advance;
   logic              issue;

   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              s1_valid_q, s1_valid_d;
   logic              s1_pad_q, s1_pad_d;
   logic              read_ready_q, read_ready_d;
   logic [width-1:0]  out_q, out_d;

   // A traversal position is consumed every unstalled FETCH cycle, pad or not
   assign advance = (state_q == ST_FETCH) && !bus.stall;
   assign issue   = advance && !pos_pad;

   cenn_raster_counter #(
      .ROWS (T_ROWS),
      .COLS (T_COLS)
   ) u_raster (
      .clk  (clk),
      .rst  (rst),
      .clr  (state_q == ST_IDLE),
      .en   (advance),
      .row  (pos_row),
      .col  (pos_col),
      .last (pos_last)
   );

`ifdef CENN_STREAMER_PAD_EN
   // Outer ring of the padded traversal carries BOUNDARY instead of RAM data
   assign pos_pad = (pos_row == '0) || (pos_row == RW'(T_ROWS - 1)) ||
                    (pos_col == '0) || (pos_col == CW'(T_COLS - 1));
`else
   // Every position is an image pixel; row/column only drive the wrap logic
   logic unused_pos;
   assign unused_pos = ^{pos_row, pos_col};
   assign pos_pad    = 1'b0;
`endif

   // Frame control: accept start, walk positions, drain the read pipe, pulse done
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_q <= ST_FETCH;
                  busy_q  <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (advance && pos_last) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // Last position reaches the output next cycle, together with done
               state_q <= ST_DONE;
               done_q  <= 1'b1;
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Address counter and the two-stage valid/data pipeline behind the RAM
   always_comb begin
      mem_addr_d = mem_addr_q;
      if (state_q == ST_IDLE) begin
         mem_addr_d = '0;
      end else if (issue) begin
         mem_addr_d = mem_addr_q + ADDR_W'(1);
      end
      s1_valid_d   = advance;
      s1_pad_d     = pos_pad;
      read_ready_d = s1_valid_q;
      out_d        = out_q;
      if (s1_valid_q) begin
         out_d = s1_pad_q ? BOUNDARY : bus.mem_data;
      end
   end

   // Datapath registers; reset discards anything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr_q   <= '0;
         s1_valid_q   <= 1'b0;
         s1_pad_q     <= 1'b0;
         read_ready_q <= 1'b0;
         out_q        <= '0;
      end else begin
         mem_addr_q   <= mem_addr_d;
         s1_valid_q   <= s1_valid_d;
         s1_pad_q     <= s1_pad_d;
         read_ready_q <= read_ready_d;
         out_q        <= out_d;
      end
   end

   assign bus.mem_en     = issue;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.out        = out_q;
   assign bus.read_ready = read_ready_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_cenn_pixel_streamer.sv
//------------------------------------------------------------------------------
// Module      : tb_cenn_pixel_streamer
// Description : Self-checking bench for cenn_pixel_streamer on a 4x4 frame
//               backed by a RAM model whose word equals its address. Expected
//               pixels are queued at frame start and compared on read_ready.
//               Honours CENN_STREAMER_PAD_EN (BOUNDARY = 8'hFF).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cenn_pixel_streamer;
   import cenn_pkg::*;

   localparam int         ROWS = 4;
   localparam int         COLS = 4;
   localparam int         W    = 8;
   localparam int         AW   = 4;
   localparam logic [7:0] BND  = 8'hFF;
`ifdef CENN_STREAMER_PAD_EN
   localparam int TR  = ROWS + 2;
   localparam int TC  = COLS + 2;
   localparam bit PAD = 1'b1;
`else
   localparam int TR  = ROWS;
   localparam int TC  = COLS;
   localparam bit PAD = 1'b0;
`endif
   localparam int NPOS = TR * TC;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cenn_pixel_streamer_if #(.width(W), .ADDR_W(AW)) bus ();

   cenn_pixel_streamer #(
      .width    (W),
      .ROWS     (ROWS),
      .COLS     (COLS),
      .ADDR_W   (AW),
      .BOUNDARY (BND)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // RAM model: one-cycle read latency, word value = address
   always @(posedge clk) begin
      if (bus.mem_en) bus.mem_data <= W'(bus.mem_addr);
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int f0 = 0;
   int rr_cnt, done_cnt, en_cnt, busy_cnt;
   int first_rr, last_rr, done_at, busy_first, busy_last;
   int sb[$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      rr_cnt = 0; done_cnt = 0; en_cnt = 0; busy_cnt = 0;
      first_rr = -1; last_rr = -1; done_at = -1; busy_first = -1; busy_last = -1;
   endtask

   // Expected stream of one frame in raster order
   task automatic push_frame();
      int idx = 0;
      for (int r = 0; r < TR; r++) begin
         for (int c = 0; c < TC; c++) begin
            if (PAD && (r == 0 || r == TR - 1 || c == 0 || c == TC - 1)) begin
               sb.push_back(int'(BND));
            end else begin
               sb.push_back(idx);
               idx++;
            end
         end
      end
   endtask

   // Start cycle of the frame is rel 0; start is sampled at its closing edge
   task automatic start_frame();
      push_frame();
      clear_stats();
      bus.start = 1'b1;
      f0 = cyc;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_rel(input int rel);
      int n = 0;
      while ((cyc - f0) < rel && n < 1000) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (done_cnt == 0 && n < limit) begin
         tick();
         n++;
      end
      if (done_cnt == 0) chk("done_timeout", 0, 1);
   endtask

   task automatic check_frame(input string tag, input int exp_done, input int exp_gap);
      chk({tag, "_rr_count"}, rr_cnt, NPOS);
      chk({tag, "_first_rr"}, first_rr, 3);
      chk({tag, "_last_rr"}, last_rr, exp_done);
      chk({tag, "_done_at"}, done_at, exp_done);
      chk({tag, "_rr_gap"}, (last_rr - first_rr + 1) - rr_cnt, exp_gap);
      chk({tag, "_mem_en_count"}, en_cnt, ROWS * COLS);
      chk({tag, "_busy_first"}, busy_first, 1);
      chk({tag, "_busy_last"}, busy_last, exp_done);
      chk({tag, "_busy_count"}, busy_cnt, exp_done);
      chk({tag, "_sb_empty"}, sb.size(), 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_mem_en"}, bus.mem_en, 0);
      chk({tag, "_mem_addr"}, bus.mem_addr, 0);
      chk({tag, "_out"}, bus.out, 0);
      chk({tag, "_read_ready"}, bus.read_ready, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_done"}, bus.done, 0);
   endtask

   // Output monitor and scoreboard, sampled on the falling edge
   always @(negedge clk) begin
      if (bus.busy) begin
         busy_cnt++;
         if (busy_first < 0) busy_first = cyc - f0;
         busy_last = cyc - f0;
      end
      if (bus.mem_en) en_cnt++;
      if (bus.read_ready) begin
         rr_cnt++;
         if (first_rr < 0) first_rr = cyc - f0;
         last_rr = cyc - f0;
         if (sb.size() == 0) begin
            chk("unexpected_pixel", 1, 0);
         end else begin
            chk("pixel", bus.out, sb.pop_front());
         end
      end
      if (bus.done) begin
         done_cnt++;
         done_at = cyc - f0;
         chk("done_with_rr", bus.read_ready, 1);
         chk("done_is_last", sb.size(), 0);
      end
   end

   initial begin
      clear_stats();
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.stall = 1'b0;
      repeat (3) tick();
      check_idle_outputs("reset");
      rst = 1'b0;
      tick();

      // Plain frame
      start_frame();
      wait_done(200);
      check_frame("basic", NPOS + 2, 0);

      // Back-to-back frame with stall during cycles 5..7
      start_frame();
      wait_rel(5);
      bus.stall = 1'b1;
      wait_rel(8);
      bus.stall = 1'b0;
      wait_done(200);
      check_frame("stall_mid", NPOS + 5, 3);

      // Start pulsed mid-frame must be ignored
      start_frame();
      wait_rel(8);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done(200);
      check_frame("restart", NPOS + 2, 0);
      repeat (4) tick();
      chk("restart_single_done", done_cnt, 1);
      chk("restart_idle_busy", bus.busy, 0);

      // Reset mid-frame at cycle 10
      start_frame();
      wait_rel(10);
      rst = 1'b1;
      tick();
      check_idle_outputs("midrst");
      sb.delete();
      rst = 1'b0;
      repeat (6) tick();
      chk("midrst_no_done", done_cnt, 0);
      chk("midrst_sb_empty", sb.size(), 0);

      // Fresh frame after reset
      start_frame();
      wait_done(200);
      check_frame("after_rst", NPOS + 2, 0);

      // Stall held across the last FETCH position
      start_frame();
      wait_rel(NPOS);
      bus.stall = 1'b1;
      wait_rel(NPOS + 3);
      bus.stall = 1'b0;
      wait_done(200);
      check_frame("stall_end", NPOS + 5, 3);

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
